// File: rtl/pr_region_decoupler.sv
// Per-region PR isolation: counts outstanding AXI bursts, drains on request, isolates, then pulses role reset.
// Zero-latency combinational handshake gating from registered state; payload buses bypass this block.
module pr_region_decoupler #(
  parameter int NUM_REGIONS     = 2,
  parameter int MAX_OUTSTANDING = 16,
  parameter int DRAIN_TIMEOUT   = 1024,
  parameter int RST_CYCLES      = 16
) (
  input  logic                   CLK_IN_250,
  input  logic                   AXI_RESET_N,
  input  logic [NUM_REGIONS-1:0] decouple_req,
  output logic [NUM_REGIONS-1:0] decoupled,
  output logic [NUM_REGIONS-1:0] drain_timeout,
  output logic [NUM_REGIONS-1:0] role_rst_n,
  input  logic [NUM_REGIONS-1:0] s_awvalid,
  input  logic [NUM_REGIONS-1:0] s_arvalid,
  input  logic [NUM_REGIONS-1:0] s_wvalid,
  output logic [NUM_REGIONS-1:0] s_awready,
  output logic [NUM_REGIONS-1:0] s_arready,
  output logic [NUM_REGIONS-1:0] s_wready,
  output logic [NUM_REGIONS-1:0] m_awvalid,
  output logic [NUM_REGIONS-1:0] m_arvalid,
  output logic [NUM_REGIONS-1:0] m_wvalid,
  input  logic [NUM_REGIONS-1:0] m_awready,
  input  logic [NUM_REGIONS-1:0] m_arready,
  input  logic [NUM_REGIONS-1:0] m_wready,
  input  logic [NUM_REGIONS-1:0] m_bvalid,
  input  logic [NUM_REGIONS-1:0] m_rvalid,
  input  logic [NUM_REGIONS-1:0] m_rlast,
  output logic [NUM_REGIONS-1:0] m_bready,
  output logic [NUM_REGIONS-1:0] m_rready,
  output logic [NUM_REGIONS-1:0] s_bvalid,
  output logic [NUM_REGIONS-1:0] s_rvalid,
  input  logic [NUM_REGIONS-1:0] s_bready,
  input  logic [NUM_REGIONS-1:0] s_rready
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TMO_LAST = TW'(DRAIN_TIMEOUT - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  typedef enum logic [1:0] {ST_RELEASE, ST_COUPLED, ST_DRAIN, ST_DECOUPLED} state_e;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    state_e        state_q, state_d;
    logic [CW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [RW-1:0] rst_q, rst_d;
    logic          to_q, to_d;
    logic          aw_en, ar_en, dat_en;
    logic          aw_hs, ar_hs, b_hs, r_hs;

    assign aw_en  = (state_q == ST_COUPLED) && (wr_q != CNT_MAX);
    assign ar_en  = (state_q == ST_COUPLED) && (rd_q != CNT_MAX);
    assign dat_en = (state_q == ST_COUPLED) || (state_q == ST_DRAIN);

    assign m_awvalid[g] = s_awvalid[g] & aw_en;
    assign s_awready[g] = m_awready[g] & aw_en;
    assign m_arvalid[g] = s_arvalid[g] & ar_en;
    assign s_arready[g] = m_arready[g] & ar_en;
    assign m_wvalid[g]  = s_wvalid[g]  & dat_en;
    assign s_wready[g]  = m_wready[g]  & dat_en;
    assign s_bvalid[g]  = m_bvalid[g]  & dat_en;
    assign m_bready[g]  = s_bready[g]  & dat_en;
    assign s_rvalid[g]  = m_rvalid[g]  & dat_en;
    assign m_rready[g]  = s_rready[g]  & dat_en;

    assign decoupled[g]     = (state_q == ST_RELEASE) || (state_q == ST_DECOUPLED);
    assign role_rst_n[g]    = (state_q != ST_RELEASE);
    assign drain_timeout[g] = to_q;

    assign aw_hs = s_awvalid[g] & m_awready[g] & aw_en;
    assign ar_hs = s_arvalid[g] & m_arready[g] & ar_en;
    assign b_hs  = m_bvalid[g] & s_bready[g] & dat_en;
    assign r_hs  = m_rvalid[g] & s_rready[g] & m_rlast[g] & dat_en;

    always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      tmr_d   = tmr_q;
      rst_d   = rst_q;
      to_d    = to_q;

      // A response with nothing outstanding is a role protocol error and is dropped.
      if (aw_hs && !b_hs)                     wr_d = wr_q + 1'b1;
      else if (b_hs && !aw_hs && wr_q != '0)  wr_d = wr_q - 1'b1;
      if (ar_hs && !r_hs)                     rd_d = rd_q + 1'b1;
      else if (r_hs && !ar_hs && rd_q != '0)  rd_d = rd_q - 1'b1;

      case (state_q)
        ST_RELEASE: begin
          wr_d = '0;
          rd_d = '0;
          if (rst_q == RST_LAST) begin
            state_d = ST_COUPLED;
            rst_d   = '0;
          end else begin
            rst_d = rst_q + 1'b1;
          end
        end
        ST_COUPLED: begin
          if (decouple_req[g]) begin
            state_d = ST_DRAIN;
            tmr_d   = '0;
            to_d    = 1'b0;
          end
        end
        ST_DRAIN: begin
          tmr_d = tmr_q + 1'b1;
          // A withdrawn request abandons the drain even if it just completed: no reset pulse is needed.
          if (!decouple_req[g]) begin
            state_d = ST_COUPLED;
          end else if (wr_q == '0 && rd_q == '0) begin
            state_d = ST_DECOUPLED;
          end else if (tmr_q == TMO_LAST) begin
            state_d = ST_DECOUPLED;
            to_d    = 1'b1;
            wr_d    = '0;
            rd_d    = '0;
          end
        end
        ST_DECOUPLED: begin
          if (!decouple_req[g]) begin
            state_d = ST_RELEASE;
            rst_d   = '0;
          end
        end
        default: state_d = ST_RELEASE;
      endcase
    end

    always_ff @(posedge CLK_IN_250 or negedge AXI_RESET_N) begin
      if (!AXI_RESET_N) begin
        state_q <= ST_RELEASE;
        wr_q    <= '0;
        rd_q    <= '0;
        tmr_q   <= '0;
        rst_q   <= '0;
        to_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        wr_q    <= wr_d;
        rd_q    <= rd_d;
        tmr_q   <= tmr_d;
        rst_q   <= rst_d;
        to_q    <= to_d;
      end
    end
  end

endmodule

// File: tb/tb_pr_region_decoupler.sv
// Random-traffic scoreboard bench for pr_region_decoupler; a per-region phase/count model predicts every gated output.
module tb_pr_region_decoupler;

  localparam int N   = 2;
  localparam int MAX = 4;
  localparam int DT  = 32;
  localparam int RST = 16;

  localparam int M_REL = 0;
  localparam int M_CPL = 1;
  localparam int M_DRN = 2;
  localparam int M_DEC = 3;

  logic         clk = 1'b0;
  logic         AXI_RESET_N;
  logic [N-1:0] decouple_req;
  logic [N-1:0] decoupled, drain_timeout, role_rst_n;
  logic [N-1:0] s_awvalid, s_arvalid, s_wvalid, s_awready, s_arready, s_wready;
  logic [N-1:0] m_awvalid, m_arvalid, m_wvalid, m_awready, m_arready, m_wready;
  logic [N-1:0] m_bvalid, m_rvalid, m_rlast, m_bready, m_rready;
  logic [N-1:0] s_bvalid, s_rvalid, s_bready, s_rready;

  always #5 clk = ~clk;

  pr_region_decoupler #(
    .NUM_REGIONS(N), .MAX_OUTSTANDING(MAX), .DRAIN_TIMEOUT(DT), .RST_CYCLES(RST)
  ) dut (
    .CLK_IN_250(clk), .AXI_RESET_N(AXI_RESET_N),
    .decouple_req(decouple_req), .decoupled(decoupled),
    .drain_timeout(drain_timeout), .role_rst_n(role_rst_n),
    .s_awvalid(s_awvalid), .s_arvalid(s_arvalid), .s_wvalid(s_wvalid),
    .s_awready(s_awready), .s_arready(s_arready), .s_wready(s_wready),
    .m_awvalid(m_awvalid), .m_arvalid(m_arvalid), .m_wvalid(m_wvalid),
    .m_awready(m_awready), .m_arready(m_arready), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_rvalid(m_rvalid), .m_rlast(m_rlast),
    .m_bready(m_bready), .m_rready(m_rready),
    .s_bvalid(s_bvalid), .s_rvalid(s_rvalid),
    .s_bready(s_bready), .s_rready(s_rready)
  );

  typedef struct packed {
    logic [N-1:0] decoupled, drain_timeout, role_rst_n;
    logic [N-1:0] s_awready, s_arready, s_wready;
    logic [N-1:0] m_awvalid, m_arvalid, m_wvalid;
    logic [N-1:0] m_bready, m_rready, s_bvalid, s_rvalid;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   done   = 0;

  // Reference model: phase per region, outstanding counts, cycles left in reset, cycles spent draining.
  int mode[N], wr[N], rd[N], rel_left[N], age[N];
  bit flag[N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mode[i] = M_REL; rel_left[i] = RST; wr[i] = 0; rd[i] = 0; age[i] = 0; flag[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      bit cpl, pass, aw, ar, b, r, was_empty;
      int nwr, nrd;
      cpl  = (mode[i] == M_CPL);
      pass = cpl || (mode[i] == M_DRN);
      aw = s_awvalid[i] && m_awready[i] && cpl && (wr[i] < MAX);
      ar = s_arvalid[i] && m_arready[i] && cpl && (rd[i] < MAX);
      b  = m_bvalid[i] && s_bready[i] && pass;
      r  = m_rvalid[i] && s_rready[i] && m_rlast[i] && pass;
      nwr = wr[i]; nrd = rd[i];
      if (aw && !b) nwr++; else if (b && !aw && nwr > 0) nwr--;
      if (ar && !r) nrd++; else if (r && !ar && nrd > 0) nrd--;
      was_empty = (wr[i] == 0) && (rd[i] == 0);
      case (mode[i])
        M_REL: begin
          wr[i] = 0; rd[i] = 0;
          rel_left[i]--;
          if (rel_left[i] == 0) mode[i] = M_CPL;
        end
        M_CPL: begin
          wr[i] = nwr; rd[i] = nrd;
          if (decouple_req[i]) begin mode[i] = M_DRN; age[i] = 0; flag[i] = 0; end
        end
        M_DRN: begin
          wr[i] = nwr; rd[i] = nrd;
          age[i]++;
          if (!decouple_req[i]) mode[i] = M_CPL;
          else if (was_empty) mode[i] = M_DEC;
          else if (age[i] == DT) begin
            mode[i] = M_DEC; flag[i] = 1; wr[i] = 0; rd[i] = 0;
          end
        end
        default: begin
          if (!decouple_req[i]) begin mode[i] = M_REL; rel_left[i] = RST; end
        end
      endcase
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    e = '0;
    for (int i = 0; i < N; i++) begin
      bit cpl, pass, aw_ok, ar_ok;
      cpl   = (mode[i] == M_CPL);
      pass  = cpl || (mode[i] == M_DRN);
      aw_ok = cpl && (wr[i] < MAX);
      ar_ok = cpl && (rd[i] < MAX);
      e.decoupled[i]     = (mode[i] == M_REL) || (mode[i] == M_DEC);
      e.role_rst_n[i]    = (mode[i] != M_REL);
      e.drain_timeout[i] = flag[i];
      e.s_awready[i] = m_awready[i] & aw_ok;
      e.m_awvalid[i] = s_awvalid[i] & aw_ok;
      e.s_arready[i] = m_arready[i] & ar_ok;
      e.m_arvalid[i] = s_arvalid[i] & ar_ok;
      e.s_wready[i]  = m_wready[i] & pass;
      e.m_wvalid[i]  = s_wvalid[i] & pass;
      e.m_bready[i]  = s_bready[i] & pass;
      e.s_bvalid[i]  = m_bvalid[i] & pass;
      e.m_rready[i]  = s_rready[i] & pass;
      e.s_rvalid[i]  = m_rvalid[i] & pass;
    end
    return e;
  endfunction

  // One cycle: advance model on the edge, then drive new stimulus and queue the expected response.
  task automatic step(input logic [N-1:0] req, input logic rst_v, input logic [N-1:0] quiet);
    @(posedge clk);
    if (AXI_RESET_N) model_edge();
    #1;
    AXI_RESET_N  = rst_v;
    decouple_req = req;
    for (int i = 0; i < N; i++) begin
      s_awvalid[i] = 1'($urandom_range(0, 1));
      s_arvalid[i] = 1'($urandom_range(0, 1));
      s_wvalid[i]  = 1'($urandom_range(0, 1));
      m_awready[i] = 1'($urandom_range(0, 1));
      m_arready[i] = 1'($urandom_range(0, 1));
      m_wready[i]  = 1'($urandom_range(0, 1));
      m_bvalid[i]  = ($urandom_range(0, 2) == 0) && !quiet[i];
      m_rvalid[i]  = ($urandom_range(0, 1) == 0) && !quiet[i];
      m_rlast[i]   = 1'($urandom_range(0, 1));
      s_bready[i]  = 1'($urandom_range(0, 1));
      s_rready[i]  = 1'($urandom_range(0, 1));
    end
    if (!rst_v) model_reset();
    exp_q.push_back(predict());
  endtask

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("decoupled",     decoupled,     e.decoupled);
        chk("drain_timeout", drain_timeout, e.drain_timeout);
        chk("role_rst_n",    role_rst_n,    e.role_rst_n);
        chk("s_awready",     s_awready,     e.s_awready);
        chk("m_awvalid",     m_awvalid,     e.m_awvalid);
        chk("s_arready",     s_arready,     e.s_arready);
        chk("m_arvalid",     m_arvalid,     e.m_arvalid);
        chk("s_wready",      s_wready,      e.s_wready);
        chk("m_wvalid",      m_wvalid,      e.m_wvalid);
        chk("m_bready",      m_bready,      e.m_bready);
        chk("s_bvalid",      s_bvalid,      e.s_bvalid);
        chk("m_rready",      m_rready,      e.m_rready);
        chk("s_rvalid",      s_rvalid,      e.s_rvalid);
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0] req, quiet;
    AXI_RESET_N  = 1'b0;
    decouple_req = '0;
    {s_awvalid, s_arvalid, s_wvalid, m_awready, m_arready, m_wready} = '0;
    {m_bvalid, m_rvalid, m_rlast, s_bready, s_rready} = '0;
    model_reset();

    repeat (3)  step(2'b00, 1'b0, 2'b00);
    // Reset sequence, then traffic with slow responses so counts reach the cap.
    repeat (40) step(2'b00, 1'b1, 2'b00);
    // Region 0 drains naturally and is released.
    repeat (40) step(2'b01, 1'b1, 2'b00);
    repeat (25) step(2'b00, 1'b1, 2'b00);
    // Region 0 silent role: forced isolation by timeout, release, then a fresh request clears the flag.
    repeat (15) step(2'b00, 1'b1, 2'b01);
    repeat (40) step(2'b01, 1'b1, 2'b01);
    repeat (25) step(2'b00, 1'b1, 2'b00);
    repeat (6)  step(2'b01, 1'b1, 2'b01);
    repeat (3)  step(2'b00, 1'b1, 2'b01);
    // Brief request toggle while traffic is outstanding.
    repeat (10) step(2'b00, 1'b1, 2'b11);
    repeat (2)  step(2'b01, 1'b1, 2'b11);
    repeat (10) step(2'b00, 1'b1, 2'b00);
    // Reset asserted mid-drain, full sequence repeats with request still held.
    repeat (10) step(2'b00, 1'b1, 2'b11);
    repeat (5)  step(2'b11, 1'b1, 2'b11);
    repeat (2)  step(2'b11, 1'b0, 2'b00);
    repeat (25) step(2'b11, 1'b1, 2'b00);
    repeat (20) step(2'b00, 1'b1, 2'b00);

    req = '0; quiet = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) quiet = 2'($urandom_range(0, 3));
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 39) == 0) req[i] = ~req[i];
      if ($urandom_range(0, 599) == 0) begin
        step(req, 1'b0, quiet);
        step(req, 1'b0, quiet);
      end
      step(req, 1'b1, quiet);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
